seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Display scan controller for the four-digit seven-segment display. It divides the system clock into a digit-refresh tick and rotates an active-low one-hot anode select. It latches the 8-bit value to be shown and applies updates only at frame boundaries, so a frame never mixes digits from two values. Its outputs feed the anode and data inputs of the binary-to-segment decoder directly downstream.

## Interface
Parameters:
- CLK_DIV, default 50000: clock cycles per digit slot; legal range 1 to 2^20.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- data_in  in  8  unsigned value to display.
- load  in  1  one-cycle strobe; captures data_in.
- blank  in  1  when high, all anodes are forced off; scanning continues.
- data_out  out  8  value currently displayed; drives the decoder data input.
- anodes  out  4  active-low one-hot digit select; drives the decoder anode input.
- frame_tick  out  1  one-cycle pulse at each frame boundary.
- pending  out  1  high while a captured value awaits the next frame boundary.

## Operation
- Prescaler: counter `div_cnt` counts 0 to CLK_DIV-1, then wraps to 0.
  - `tick` is asserted combinationally when `div_cnt == CLK_DIV-1`.
  - With CLK_DIV=1, `tick` is asserted every cycle.
- Digit FSM has states D0, D1, D2, D3 and advances one state per `tick`: D0→D1→D2→D3→D0.
  - The anode pattern follows the state: D0=1110, D1=1101, D2=1011, D3=0111.
  - Digit 0 is the least significant.
- Frame boundary: `tick` while in state D3.
- Load buffer: `load` captures data_in into `pend_reg` and sets `pending`.
  - A second load before the boundary overwrites `pend_reg`. The last value wins.
- At a frame boundary with `pending` set: data_out ← `pend_reg` and `pending` clears.
- At a frame boundary with `pending` clear: data_out holds.
- Load and boundary in the same cycle: data_out ← data_in directly and `pending` stays clear. The new value is never deferred by a full frame.
- frame_tick asserts for exactly one cycle on every frame boundary, whether or not data_out changes.
- blank:
  - While high, anodes = 1111.
  - The FSM, prescaler and load logic continue unaffected.
  - On deassertion, anodes show the current state's pattern on the next registered update.
- Reset, while rst_n is low at a clock edge:
  - `div_cnt` = 0 and state = D0.
  - anodes = 1110, or 1111 if blank was high at that edge.
  - data_out = 0x00, `pend_reg` = 0x00, pending = 0, frame_tick = 0.
  - A load asserted in the same cycle as reset is discarded.
- Reset mid-frame abandons the frame and any pending value. Scanning restarts at D0 with a full CLK_DIV slot.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- anodes change on the clock edge that consumes `tick`. Each digit is therefore held for exactly CLK_DIV cycles.
- After reset release, anodes = 1110 for CLK_DIV cycles, then 1101.
- A full frame is 4·CLK_DIV cycles.
- frame_tick is high in the cycle immediately after the boundary edge. It coincides with the first cycle of D0 (anodes = 1110) and with the updated data_out.
- load latency to pending = 1 cycle.
- load latency to data_out ranges from 1 cycle (load on the boundary) to 4·CLK_DIV cycles.
- blank latency = 1 cycle, both on assertion and on deassertion.

## Test plan
- **Reset and scan.** Set CLK_DIV=4 and hold rst_n low for 2 cycles, then release.
  - Required: anodes = 1110 for cycles 1–4, 1101 for 5–8, 1011 for 9–12, 0111 for 13–16, then 1110 again.
  - Required: frame_tick is high only in cycle 17.
  - Required: data_out = 0x00 throughout.
- **Deferred load.** Set CLK_DIV=4 and pulse load with data_in=0xC8 in D1.
  - Required: pending = 1 from the next cycle.
  - Required: data_out stays 0x00 until the boundary, then reads 0xC8 together with frame_tick.
  - Required: pending = 0 afterwards.
- **Back-to-back loads.** In one frame, load 0x11 in D0, then 0x2A in D2.
  - Required: at the boundary, data_out = 0x2A.
  - Required: 0x11 never appears on data_out.
- **Load on the boundary.** Pulse load with data_in=0xFF in the cycle where state = D3 and `div_cnt` = CLK_DIV-1.
  - Required: data_out = 0xFF on the next cycle.
  - Required: pending stays 0 and frame_tick pulses.
- **Blank.** Raise blank for 6 cycles during D2.
  - Required: anodes = 1111 one cycle after blank rises.
  - Required: the FSM still reaches D3 on schedule.
  - Required: anodes = 0111 or 1110, whichever matches the current state, one cycle after blank falls.
- **Reset mid-operation and CLK_DIV=1.**
  - Load 0x55, then assert rst_n=0 before the boundary. Required: data_out = 0x00, pending = 0, anodes = 1110.
  - With CLK_DIV=1: required: anodes rotate every cycle and frame_tick pulses every 4th cycle.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller
// Rotates an active-low anode select and swaps the displayed value only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       blank,
  output logic [7:0] data_out,
  output logic [3:0] anodes,
  output logic       frame_tick,
  output logic       pending
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {D0, D1, D2, D3} digit_t;

  digit_t           state;
  digit_t           state_nxt;
  logic [CNT_W-1:0] div_cnt;
  logic             tick;
  logic             boundary;
  logic [7:0]       pend_reg;
  logic [3:0]       anode_nxt;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (state == D3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= D0;
    end else begin
      state <= state_nxt;
    end
  end

  // Anode pattern is decoded from the next state so the register lands with the digit change.
  always_comb begin
    state_nxt = state;
    anode_nxt = 4'b1110;
    if (tick) begin
      case (state)
        D0:      state_nxt = D1;
        D1:      state_nxt = D2;
        D2:      state_nxt = D3;
        D3:      state_nxt = D0;
        default: state_nxt = D0;
      endcase
    end
    case (state_nxt)
      D0:      anode_nxt = 4'b1110;
      D1:      anode_nxt = 4'b1101;
      D2:      anode_nxt = 4'b1011;
      D3:      anode_nxt = 4'b0111;
      default: anode_nxt = 4'b1110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anodes     <= blank ? 4'b1111 : 4'b1110;
      frame_tick <= 1'b0;
    end else begin
      anodes     <= blank ? 4'b1111 : anode_nxt;
      frame_tick <= boundary;
    end
  end

  // A load coinciding with the boundary bypasses the buffer so it is not held a whole frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out <= 8'h00;
      pend_reg <= 8'h00;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        pend_reg <= data_in;
      end
      if (boundary) begin
        pending <= 1'b0;
        if (load) begin
          data_out <= data_in;
        end else if (pending) begin
          data_out <= pend_reg;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       load;
  logic       blank;
  logic [7:0] data_out;
  logic [3:0] anodes;
  logic       frame_tick;
  logic       pending;

  logic       rst1_n;
  logic       blank1;
  logic [7:0] data_out1;
  logic [3:0] anodes1;
  logic       frame_tick1;
  logic       pending1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic blank_q = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .load(load), .blank(blank),
    .data_out(data_out), .anodes(anodes), .frame_tick(frame_tick), .pending(pending)
  );

  seg_scan_ctrl #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .data_in(8'h00), .load(1'b0), .blank(blank1),
    .data_out(data_out1), .anodes(anodes1), .frame_tick(frame_tick1), .pending(pending1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    blank_q = blank;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] exp_anodes(input int c, input int div, input logic blk);
    int slot;
    slot = ((c - 1) / div) % 4;
    if (blk) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  task automatic check_scan();
    check("anodes", anodes, exp_anodes(cyc, 4, blank_q));
    check("frame_tick", frame_tick, (cyc > 1) && ((cyc - 1) % 16 == 0));
  endtask

  task automatic run_to(input int c, input logic [7:0] exp_data);
    while (cyc < c) begin
      step();
      check_scan();
      check("data_hold", data_out, exp_data);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; data_in = 8'h00; load = 1'b0; blank = 1'b0; blank1 = 1'b0;

    // Reset with blank high and a load that must be discarded.
    blank = 1'b1; load = 1'b1; data_in = 8'h77;
    step();
    check("rst_anodes_blank", anodes, 4'b1111);
    check("rst_pending", pending, 1'b0);
    blank = 1'b0; load = 1'b0;
    step();
    check("rst_anodes", anodes, 4'b1110);
    check("rst_data", data_out, 8'h00);
    check("rst_frame_tick", frame_tick, 1'b0);
    rst_n = 1'b1;
    cyc = 1;
    check_scan();

    // Plain scan through the first frame, D1 load of 0xC8 at cycle 6.
    run_to(6, 8'h00);
    load = 1'b1; data_in = 8'hC8;
    step();
    load = 1'b0;
    check_scan();
    check("defer_pending", pending, 1'b1);
    run_to(16, 8'h00);
    check("defer_pending_hold", pending, 1'b1);
    step();
    check_scan();
    check("defer_data", data_out, 8'hC8);
    check("defer_pending_clr", pending, 1'b0);

    // Back-to-back loads: 0x11 in D0, 0x2A in D2; only 0x2A may show.
    step();
    check_scan();
    load = 1'b1; data_in = 8'h11;
    step();
    load = 1'b0;
    check_scan();
    run_to(26, 8'hC8);
    load = 1'b1; data_in = 8'h2A;
    step();
    load = 1'b0;
    check_scan();
    check("b2b_pending", pending, 1'b1);
    run_to(32, 8'hC8);
    step();
    check_scan();
    check("b2b_data", data_out, 8'h2A);

    // Load exactly on the boundary cycle (D3, div_cnt==3 is cycle 48).
    run_to(48, 8'h2A);
    load = 1'b1; data_in = 8'hFF;
    step();
    load = 1'b0;
    check_scan();
    check("bnd_data", data_out, 8'hFF);
    check("bnd_pending", pending, 1'b0);
    check("bnd_frame_tick", frame_tick, 1'b1);

    // Blank for 6 cycles starting in D2 (cycle 57), released into D3.
    run_to(57, 8'hFF);
    blank = 1'b1;
    run_to(63, 8'hFF);
    blank = 1'b0;
    check("blank_on", anodes, 4'b1111);
    step();
    check_scan();
    check("blank_off", anodes, 4'b0111);
    run_to(65, 8'hFF);
    check("blank_frame_tick", frame_tick, 1'b1);

    // Mid-frame reset drops a pending value.
    load = 1'b1; data_in = 8'h55;
    step();
    load = 1'b0;
    check("mid_pending", pending, 1'b1);
    rst_n = 1'b0;
    step();
    check("mid_rst_data", data_out, 8'h00);
    check("mid_rst_pending", pending, 1'b0);
    check("mid_rst_anodes", anodes, 4'b1110);
    rst_n = 1'b1;
    cyc = 1;
    run_to(20, 8'h00);
    check("mid_no_pending", pending, 1'b0);

    // CLK_DIV=1: one digit per cycle, frame_tick every 4th cycle.
    step();
    rst1_n = 1'b1;
    cyc = 1;
    check("div1_anodes", anodes1, exp_anodes(cyc, 1, 1'b0));
    for (int i = 0; i < 12; i++) begin
      step();
      check("div1_anodes", anodes1, exp_anodes(cyc, 1, 1'b0));
      check("div1_frame_tick", frame_tick1, (cyc - 1) % 4 == 0);
    end
    check("div1_data", data_out1, 8'h00);
    check("div1_pending", pending1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
